// File: rtl/flash_cmd_responder.sv
// Flash-style command responder: unlock/program/erase/ID/status over a 16x8 array.
// Read data appears one cycle after the read event; no backpressure, writes while busy are rejected.
module flash_cmd_responder #(
    parameter int         PROG_CYCLES = 4,
    parameter logic [7:0] ID_CODE     = 8'hC2
) (
    input  logic       SCL,
    input  logic       reset,
    input  logic       CE_N,
    input  logic       WE_N,
    input  logic       OE_N,
    input  logic [3:0] Addr,
    input  logic [7:0] DInDOut,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        IDLE, UNLK1, UNLK2, PROG_WAIT, PROG_BUSY, ERASE_BUSY, ID_MODE, STAT_MODE
    } state_t;

    localparam logic [3:0] PROG_LAST = 4'(PROG_CYCLES - 1);

    state_t     state;
    logic       we_q;
    logic [3:0] cnt;
    logic       fail;
    logic [7:0] mem [16];
    logic       write_ev;
    logic       read_ev;
    logic [7:0] status;
    logic [7:0] prog_val;

    // A write completes on the rising edge of WE_N while the chip is enabled.
    assign write_ev = WE_N & ~we_q & ~CE_N;
    assign read_ev  = ~CE_N & ~OE_N & ~write_ev;
    assign busy     = (state == PROG_BUSY) || (state == ERASE_BUSY);
    assign status   = {~busy, 6'b0, fail};
    assign prog_val = mem[Addr] & DInDOut;

    always_ff @(posedge SCL) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b1;
            cnt        <= 4'd0;
            fail       <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            cmd_err    <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
        end else begin
            we_q       <= WE_N;
            cmd_err    <= 1'b0;
            data_valid <= 1'b0;

            if (read_ev) begin
                data_valid <= 1'b1;
                if (busy || state == STAT_MODE) data_out <= status;
                else if (state == ID_MODE)      data_out <= ID_CODE;
                else                            data_out <= mem[Addr];
            end

            case (state)
                PROG_BUSY: begin
                    if (write_ev) cmd_err <= 1'b1;
                    if (cnt == PROG_LAST) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ERASE_BUSY: begin
                    if (write_ev) cmd_err <= 1'b1;
                    mem[cnt] <= 8'hFF;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= IDLE;
                end
                PROG_WAIT: begin
                    // Programming can only clear bits; a byte that needed a 0->1 flags failure.
                    if (write_ev) begin
                        mem[Addr] <= prog_val;
                        if (prog_val != DInDOut) fail <= 1'b1;
                        state <= PROG_BUSY;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    if (write_ev) begin
                        if (DInDOut == 8'h00) begin
                            state <= IDLE;
                            fail  <= 1'b0;
                        end else begin
                            case (state)
                                UNLK1: begin
                                    if (DInDOut == 8'h55) begin
                                        state <= UNLK2;
                                    end else begin
                                        state   <= IDLE;
                                        cmd_err <= 1'b1;
                                    end
                                end
                                UNLK2: begin
                                    case (DInDOut)
                                        8'hB0:   state <= PROG_WAIT;
                                        8'hC0:   state <= ID_MODE;
                                        8'hD0: begin
                                            state <= ERASE_BUSY;
                                            cnt   <= 4'd0;
                                        end
                                        8'hE0:   state <= STAT_MODE;
                                        default: begin
                                            state   <= IDLE;
                                            cmd_err <= 1'b1;
                                        end
                                    endcase
                                end
                                default: begin
                                    if (DInDOut == 8'hAA) state <= UNLK1;
                                    else                  cmd_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_responder.sv
// Bench for flash_cmd_responder: directed command sequences, read data checked by a queue-based monitor.
module tb_flash_cmd_responder;

    logic       SCL = 1'b0;
    logic       reset;
    logic       CE_N;
    logic       WE_N;
    logic       OE_N;
    logic [3:0] Addr;
    logic [7:0] DInDOut;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       cmd_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    flash_cmd_responder dut (
        .SCL        (SCL),
        .reset      (reset),
        .CE_N       (CE_N),
        .WE_N       (WE_N),
        .OE_N       (OE_N),
        .Addr       (Addr),
        .DInDOut    (DInDOut),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 SCL = ~SCL;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two-cycle write strobe; the write event lands on the second edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic err);
        CE_N = 1'b0; WE_N = 1'b0; Addr = a; DInDOut = d;
        @(posedge SCL); #1 WE_N = 1'b1;
        @(posedge SCL); #1 CE_N = 1'b1;
        chk($sformatf("cmd_err after write %h", d), {7'b0, cmd_err}, {7'b0, err});
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        CE_N = 1'b0; OE_N = 1'b0; Addr = a;
        @(posedge SCL); #1 CE_N = 1'b1; OE_N = 1'b1;
    endtask

    task automatic unlock(input logic [7:0] cmd);
        wr(4'd0, 8'hAA, 1'b0);
        wr(4'd0, 8'h55, 1'b0);
        wr(4'd0, cmd, 1'b0);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge SCL); #1;
        end
    endtask

    always @(negedge SCL) begin
        if (reset === 1'b0 && data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected read data: got %h expected no data_valid", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL read data: got %h expected %h", data_out, e);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; CE_N = 1'b1; WE_N = 1'b1; OE_N = 1'b1; Addr = 4'd0; DInDOut = 8'h00;
        repeat (3) @(posedge SCL);
        #1 reset = 1'b0;
        chk("reset data_out", data_out, 8'h00);
        chk("reset data_valid", {7'b0, data_valid}, 8'h00);
        chk("reset busy", {7'b0, busy}, 8'h00);
        chk("reset cmd_err", {7'b0, cmd_err}, 8'h00);

        // Program 3C at address 5, then status
        unlock(8'hB0);
        wr(4'd5, 8'h3C, 1'b0);
        wait_busy(n);
        chk("program busy cycles", 8'(n), 8'd4);
        rd(4'd5, 8'h3C);
        unlock(8'hE0);
        rd(4'd0, 8'h80);
        wr(4'd0, 8'h00, 1'b0);

        // Failed program sets sticky flag; 00 clears it
        unlock(8'hB0);
        wr(4'd2, 8'h0F, 1'b0);
        wait_busy(n);
        unlock(8'hB0);
        wr(4'd2, 8'hF0, 1'b0);
        wait_busy(n);
        rd(4'd2, 8'h00);
        unlock(8'hE0);
        rd(4'd1, 8'h81);
        wr(4'd0, 8'h00, 1'b0);
        unlock(8'hE0);
        rd(4'd1, 8'h80);
        wr(4'd0, 8'h00, 1'b0);

        // ID mode
        unlock(8'hC0);
        rd(4'd7, 8'hC2);
        rd(4'd5, 8'hC2);
        wr(4'd0, 8'h00, 1'b0);
        rd(4'd5, 8'h3C);
        rd(4'd2, 8'h00);

        // Bad unlock sequence returns to IDLE with a single-cycle error pulse
        wr(4'd0, 8'hAA, 1'b0);
        wr(4'd0, 8'h12, 1'b1);
        @(posedge SCL); #1;
        chk("cmd_err pulse width", {7'b0, cmd_err}, 8'h00);
        wr(4'd0, 8'h55, 1'b1);

        // Erase: status during busy, rejected write, 16 busy cycles, array all FF
        unlock(8'hD0);
        rd(4'd0, 8'h00);
        wr(4'd3, 8'h00, 1'b1);
        wait_busy(n);
        chk("erase busy cycles", 8'(n + 3), 8'd16);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'hFF);

        // Reset in the middle of an erase
        unlock(8'hB0);
        wr(4'd9, 8'h11, 1'b0);
        wait_busy(n);
        rd(4'd9, 8'h11);
        unlock(8'hD0);
        @(posedge SCL); #1 reset = 1'b1;
        @(posedge SCL); #1 reset = 1'b0;
        chk("busy after reset", {7'b0, busy}, 8'h00);
        chk("data_out after reset", data_out, 8'h00);
        rd(4'd9, 8'hFF);
        rd(4'd0, 8'hFF);
        wr(4'd0, 8'h55, 1'b1);

        repeat (3) @(posedge SCL);
        #1;
        chk("reads outstanding", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
